// File: rtl/exe_stage_iter_if.sv
// exe_stage_iter_if: ID/EXE issue bundle and EXE/MEM result bundle for exe_stage_iter
//   master: upstream/issuing side, drives issue fields and flush, observes in_ready and results
//   slave:  the execute stage, consumes issue fields and drives in_ready and registered results
interface exe_stage_iter_if #(
   parameter int WIDTH   = 32,
   parameter int IMM_LEN = 24
);
   logic               flush, in_valid, in_ready;
   logic [3:0]         exec_cmd, dest_in, status_reg_out;
   logic               mul_en, mla_en, s_en, mem_r_en_in, mem_w_en_in, wb_en_in, imm;
   logic [11:0]        shift_operand;
   logic [IMM_LEN-1:0] signed_imm;
   logic [WIDTH-1:0]   pc_in, val_1, val_r_m_in, val_s, mem_wb_val, wb_wb_val;
   logic [1:0]         alu_src1_mux_sel, alu_src2_mux_sel;
   logic               out_valid, status_we, wb_en, mem_r_en, mem_w_en;
   logic [WIDTH-1:0]   alu_res, val_r_m, branch_addr;
   logic [3:0]         status_reg_in, dest;
   modport master (
      output flush, in_valid, exec_cmd, dest_in, status_reg_out, mul_en, mla_en, s_en,
             mem_r_en_in, mem_w_en_in, wb_en_in, imm, shift_operand, signed_imm, pc_in,
             val_1, val_r_m_in, val_s, mem_wb_val, wb_wb_val, alu_src1_mux_sel, alu_src2_mux_sel,
      input  in_ready, out_valid, status_we, wb_en, mem_r_en, mem_w_en, alu_res, val_r_m,
             branch_addr, status_reg_in, dest
   );
   modport slave (
      input  flush, in_valid, exec_cmd, dest_in, status_reg_out, mul_en, mla_en, s_en,
             mem_r_en_in, mem_w_en_in, wb_en_in, imm, shift_operand, signed_imm, pc_in,
             val_1, val_r_m_in, val_s, mem_wb_val, wb_wb_val, alu_src1_mux_sel, alu_src2_mux_sel,
      output in_ready, out_valid, status_we, wb_en, mem_r_en, mem_w_en, alu_res, val_r_m,
             branch_addr, status_reg_in, dest
   );
endinterface

// File: rtl/exe_stage_iter.sv
// exe_stage_iter: registered ARM execute stage with iterative MUL/MLA and 3-way operand forwarding
//   clk: rising-edge clock; rst: synchronous active-low reset
//   b (slave): issue fields + in_valid/in_ready/flush in, registered EXE/MEM results out
module exe_stage_iter #(
   parameter int WIDTH    = 32,
   parameter int IMM_LEN  = 24,
   parameter int MUL_STEP = 2
) (
   input logic             clk,
   input logic             rst,
   exe_stage_iter_if.slave b
);
   localparam int K  = WIDTH / MUL_STEP;
   localparam int CW = K > 1 ? $clog2(K) : 1;
   typedef enum logic {IDLE, MUL} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] src1, src2, imm8, imm_rot, asr, reg_sh, val_2, b_op, alu, br;
   logic [WIDTH-1:0] mcand, mplier, acc, acc_n, digit;
   logic [WIDTH:0]   sum;
   logic [4:0]       rot, sh_amt;
   logic [3:0]       flags, m_dest;
   logic [1:0]       m_cv;
   logic [CW-1:0]    cnt;
   logic             sub, arith, cin, accept, last, m_wb, m_mr, m_mw, m_s;
   assign b.in_ready = state == IDLE;
   always_comb begin
      src1    = b.alu_src1_mux_sel == 2'd1 ? b.mem_wb_val : b.alu_src1_mux_sel == 2'd2 ? b.wb_wb_val : b.val_1;
      src2    = b.alu_src2_mux_sel == 2'd1 ? b.mem_wb_val : b.alu_src2_mux_sel == 2'd2 ? b.wb_wb_val : b.val_r_m_in;
      imm8    = WIDTH'(b.shift_operand[7:0]);
      rot     = {b.shift_operand[11:8], 1'b0};
      imm_rot = (imm8 >> rot) | (imm8 << (WIDTH - int'(rot)));
      sh_amt  = b.shift_operand[11:7];
      asr     = $signed(src2) >>> sh_amt;
      reg_sh  = b.shift_operand[6:5] == 2'd0 ? src2 << sh_amt :
                b.shift_operand[6:5] == 2'd1 ? src2 >> sh_amt :
                b.shift_operand[6:5] == 2'd2 ? asr : (src2 >> sh_amt) | (src2 << (WIDTH - int'(sh_amt)));
      // loads/stores always use the raw 12-bit offset, ignoring imm and shift fields
      val_2   = (b.mem_r_en_in || b.mem_w_en_in) ? WIDTH'(b.shift_operand) : b.imm ? imm_rot : reg_sh;
      // SUB/SBC run as src1 + ~val_2 + cin so the carry out is ARM's not-borrow
      sub     = b.exec_cmd == 4'b0100 || b.exec_cmd == 4'b0101;
      arith   = sub || b.exec_cmd == 4'b0010 || b.exec_cmd == 4'b0011;
      cin     = (b.exec_cmd == 4'b0011 || b.exec_cmd == 4'b0101) ? b.status_reg_out[1] : sub;
      b_op    = sub ? ~val_2 : val_2;
      sum     = {1'b0, src1} + {1'b0, b_op} + (WIDTH+1)'(cin);
      alu     = b.exec_cmd == 4'b0001 ? val_2 : b.exec_cmd == 4'b1001 ? ~val_2 : arith ? sum[WIDTH-1:0] :
                b.exec_cmd == 4'b0110 ? src1 & val_2 : b.exec_cmd == 4'b0111 ? src1 | val_2 :
                b.exec_cmd == 4'b1000 ? src1 ^ val_2 : '0;
      flags   = {alu[WIDTH-1], alu == '0, arith ? sum[WIDTH] : b.status_reg_out[1],
                 arith ? (src1[WIDTH-1] == b_op[WIDTH-1] && sum[WIDTH-1] != src1[WIDTH-1]) : b.status_reg_out[0]};
      br      = b.pc_in + ({{(WIDTH-IMM_LEN){b.signed_imm[IMM_LEN-1]}}, b.signed_imm} << 2);
      // mplier is shifted down each step, so its low digit is always the next one to retire
      digit   = WIDTH'(mplier[MUL_STEP-1:0]);
      acc_n   = acc + ((mcand * digit) << (int'(cnt) * MUL_STEP));
      accept  = b.in_valid && b.in_ready && !b.flush;
      last    = state == MUL && cnt == CW'(K - 1);
      state_n = b.flush ? IDLE : (accept && b.mul_en) ? MUL : last ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         b.out_valid     <= 1'b0;
         b.wb_en         <= 1'b0;
         b.mem_r_en      <= 1'b0;
         b.mem_w_en      <= 1'b0;
         b.status_we     <= 1'b0;
         b.alu_res       <= '0;
         b.val_r_m       <= '0;
         b.branch_addr   <= '0;
         b.status_reg_in <= '0;
         b.dest          <= '0;
         mcand           <= '0;
         mplier          <= '0;
         acc             <= '0;
         cnt             <= '0;
         m_dest          <= '0;
         m_cv            <= '0;
         {m_wb, m_mr, m_mw, m_s} <= '0;
      end else begin
         b.out_valid <= 1'b0;
         b.wb_en     <= 1'b0;
         b.mem_r_en  <= 1'b0;
         b.mem_w_en  <= 1'b0;
         b.status_we <= 1'b0;
         if (accept && !b.mul_en) begin
            b.out_valid     <= 1'b1;
            b.alu_res       <= alu;
            b.status_reg_in <= flags;
            b.val_r_m       <= src2;
            b.branch_addr   <= br;
            b.dest          <= b.dest_in;
            b.wb_en         <= b.wb_en_in;
            b.mem_r_en      <= b.mem_r_en_in;
            b.mem_w_en      <= b.mem_w_en_in;
            b.status_we     <= b.s_en;
         end else if (accept) begin
            mcand  <= src2;
            mplier <= b.val_s;
            acc    <= b.mla_en ? src1 : '0;
            cnt    <= '0;
            m_dest <= b.dest_in;
            m_cv   <= b.status_reg_out[1:0];
            {m_wb, m_mr, m_mw, m_s} <= {b.wb_en_in, b.mem_r_en_in, b.mem_w_en_in, b.s_en};
         end else if (state == MUL && !b.flush) begin
            acc    <= acc_n;
            mplier <= mplier >> MUL_STEP;
            cnt    <= cnt + 1'b1;
            if (last) begin
               b.out_valid     <= 1'b1;
               b.alu_res       <= acc_n;
               b.status_reg_in <= {acc_n[WIDTH-1], acc_n == '0, m_cv};
               b.val_r_m       <= mcand;
               b.dest          <= m_dest;
               b.wb_en         <= m_wb;
               b.mem_r_en      <= m_mr;
               b.mem_w_en      <= m_mw;
               b.status_we     <= m_s;
            end
         end
      end
   end
endmodule

// File: tb/tb_exe_stage_iter.sv
// tb_exe_stage_iter: table-driven and scoreboarded checks of exe_stage_iter
module tb_exe_stage_iter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   exe_stage_iter_if #(.WIDTH(32), .IMM_LEN(24)) b ();
   exe_stage_iter_if #(.WIDTH(32), .IMM_LEN(24)) b4 ();
   exe_stage_iter #(.WIDTH(32), .IMM_LEN(24), .MUL_STEP(2)) dut (.clk(clk), .rst(rst), .b(b));
   exe_stage_iter #(.WIDTH(32), .IMM_LEN(24), .MUL_STEP(4)) dut4 (.clk(clk), .rst(rst), .b(b4));

   typedef struct {
      logic [3:0]  cmd;
      logic        imm, mr, mw, s;
      logic [11:0] sh;
      logic [3:0]  dest, st;
      logic [1:0]  s1, s2;
      logic [31:0] v1, vrm, mwb, wwb, pc;
      logic [23:0] simm;
      logic [31:0] e_res, e_br, e_vrm;
      logic [3:0]  e_fl;
   } vec_t;
   typedef struct {
      logic [31:0] res, br, vrm;
      logic [3:0]  fl, dest;
      logic        we, wb, mr, mw, is_mul;
   } exp_t;

   exp_t sb[$];
   vec_t v[11];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && b.out_valid) begin
         if (sb.size() == 0) chk("unexpected_out_valid", 32'(b.out_valid), 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("alu_res", b.alu_res, e.res);
            chk("status_reg_in", 32'(b.status_reg_in), 32'(e.fl));
            chk("status_we", 32'(b.status_we), 32'(e.we));
            chk("dest", 32'(b.dest), 32'(e.dest));
            chk("wb_en", 32'(b.wb_en), 32'(e.wb));
            chk("mem_r_en", 32'(b.mem_r_en), 32'(e.mr));
            chk("mem_w_en", 32'(b.mem_w_en), 32'(e.mw));
            if (!e.is_mul) begin
               chk("branch_addr", b.branch_addr, e.br);
               chk("val_r_m", b.val_r_m, e.vrm);
            end
         end
      end
   end

   task automatic init_bus();
      b.flush = 0; b.in_valid = 0; b.exec_cmd = 0; b.dest_in = 0; b.status_reg_out = 0;
      b.mul_en = 0; b.mla_en = 0; b.s_en = 0; b.mem_r_en_in = 0; b.mem_w_en_in = 0; b.wb_en_in = 0;
      b.imm = 0; b.shift_operand = 0; b.signed_imm = 0; b.pc_in = 0; b.val_1 = 0; b.val_r_m_in = 0;
      b.val_s = 0; b.mem_wb_val = 0; b.wb_wb_val = 0; b.alu_src1_mux_sel = 0; b.alu_src2_mux_sel = 0;
      b4.flush = 0; b4.in_valid = 0; b4.exec_cmd = 0; b4.dest_in = 0; b4.status_reg_out = 0;
      b4.mul_en = 0; b4.mla_en = 0; b4.s_en = 0; b4.mem_r_en_in = 0; b4.mem_w_en_in = 0; b4.wb_en_in = 0;
      b4.imm = 0; b4.shift_operand = 0; b4.signed_imm = 0; b4.pc_in = 0; b4.val_1 = 0; b4.val_r_m_in = 0;
      b4.val_s = 0; b4.mem_wb_val = 0; b4.wb_wb_val = 0; b4.alu_src1_mux_sel = 0; b4.alu_src2_mux_sel = 0;
   endtask

   task automatic idle();
      b.in_valid = 0; b.mul_en = 0; b.mla_en = 0; b.s_en = 0;
   endtask

   task automatic issue(input vec_t x);
      b.in_valid = 1; b.mul_en = 0; b.mla_en = 0; b.exec_cmd = x.cmd; b.imm = x.imm;
      b.shift_operand = x.sh; b.mem_r_en_in = x.mr; b.mem_w_en_in = x.mw; b.wb_en_in = ~x.mw;
      b.s_en = x.s; b.dest_in = x.dest; b.status_reg_out = x.st; b.alu_src1_mux_sel = x.s1;
      b.alu_src2_mux_sel = x.s2; b.val_1 = x.v1; b.val_r_m_in = x.vrm; b.mem_wb_val = x.mwb;
      b.wb_wb_val = x.wwb; b.pc_in = x.pc; b.signed_imm = x.simm; b.val_s = 0;
      sb.push_back('{res: x.e_res, br: x.e_br, vrm: x.e_vrm, fl: x.e_fl, dest: x.dest,
                     we: x.s, wb: ~x.mw, mr: x.mr, mw: x.mw, is_mul: 1'b0});
      @(negedge clk);
   endtask

   task automatic issue_mul(input logic mla, input logic [31:0] rn, rm, rs, input logic [1:0] s2sel,
                            input logic [31:0] mwb, input logic [3:0] st, input logic [31:0] e_res,
                            input logic [3:0] e_fl, input logic push);
      b.in_valid = 1; b.mul_en = 1; b.mla_en = mla; b.s_en = 1; b.wb_en_in = 1; b.mem_r_en_in = 0;
      b.mem_w_en_in = 0; b.dest_in = 4'hA; b.exec_cmd = 0; b.imm = 0; b.shift_operand = 0;
      b.val_1 = rn; b.val_r_m_in = rm; b.val_s = rs; b.alu_src1_mux_sel = 0; b.alu_src2_mux_sel = s2sel;
      b.mem_wb_val = mwb; b.status_reg_out = st;
      if (push) sb.push_back('{res: e_res, br: 32'd0, vrm: 32'd0, fl: e_fl, dest: 4'hA,
                               we: 1'b1, wb: 1'b1, mr: 1'b0, mw: 1'b0, is_mul: 1'b1});
      @(negedge clk);
      idle();
      b.mem_wb_val = ~mwb;
      b.val_r_m_in = ~rm;
      b.status_reg_out = ~st;
   endtask

   task automatic busy_cycles(output int n);
      n = 0;
      while (!b.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(b.out_valid), 32'd0);
      chk({tag, "_alu_res"}, b.alu_res, 32'd0);
      chk({tag, "_val_r_m"}, b.val_r_m, 32'd0);
      chk({tag, "_branch_addr"}, b.branch_addr, 32'd0);
      chk({tag, "_status_reg_in"}, 32'(b.status_reg_in), 32'd0);
      chk({tag, "_dest"}, 32'(b.dest), 32'd0);
      chk({tag, "_ctrl"}, 32'({b.wb_en, b.mem_r_en, b.mem_w_en, b.status_we}), 32'd0);
      chk({tag, "_in_ready"}, 32'(b.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      init_bus();
      v[0]  = '{default: 0, cmd: 4'h2, imm: 1, sh: 12'h005, s: 1, s1: 2'd1, mwb: 32'd10, v1: 32'd99,
                vrm: 32'h1234, pc: 32'h100, simm: 24'hFFFFFE, e_res: 32'd15, e_br: 32'hF8, e_vrm: 32'h1234};
      v[1]  = '{default: 0, cmd: 4'h4, s: 1, v1: 32'd5, vrm: 32'd5, pc: 32'h2000, simm: 24'h10,
                e_res: 32'd0, e_fl: 4'b0110, e_br: 32'h2040, e_vrm: 32'd5};
      v[2]  = '{default: 0, cmd: 4'h4, s: 1, s2: 2'd2, wwb: 32'd5, vrm: 32'd77, v1: 32'd3,
                e_res: 32'hFFFFFFFE, e_fl: 4'b1000, e_vrm: 32'd5};
      v[3]  = '{default: 0, cmd: 4'h2, imm: 1, sh: 12'h001, s: 1, v1: 32'h7FFFFFFF,
                e_res: 32'h80000000, e_fl: 4'b1001};
      v[4]  = '{default: 0, cmd: 4'h1, imm: 1, sh: 12'h4FF, st: 4'b0011, pc: 32'h3000, simm: 24'h800000,
                e_res: 32'hFF000000, e_fl: 4'b1011, e_br: 32'hFE003000};
      v[5]  = '{default: 0, cmd: 4'h2, mr: 1, imm: 1, sh: 12'h804, v1: 32'h1000, e_res: 32'h1804};
      v[6]  = '{default: 0, cmd: 4'h8, sh: 12'h220, s: 1, vrm: 32'hF0, v1: 32'hFF,
                e_res: 32'hF0, e_vrm: 32'hF0};
      v[7]  = '{default: 0, cmd: 4'h9, sh: 12'h240, s: 1, vrm: 32'h80000000, st: 4'b1111,
                e_res: 32'h07FFFFFF, e_fl: 4'b0011, e_vrm: 32'h80000000};
      v[8]  = '{default: 0, cmd: 4'h3, imm: 1, sh: 12'h001, s: 1, v1: 32'hFFFFFFFF, st: 4'b0010,
                e_res: 32'd1, e_fl: 4'b0010};
      v[9]  = '{default: 0, cmd: 4'h6, imm: 1, sh: 12'h0FF, s: 1, s1: 2'd2, wwb: 32'hF0F0, e_res: 32'hF0};
      v[10] = '{default: 0, cmd: 4'h2, mw: 1, sh: 12'h008, v1: 32'h40, vrm: 32'hDEAD,
                e_res: 32'h48, e_vrm: 32'hDEAD};
      for (int i = 0; i < 11; i++) v[i].dest = 4'(i);
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) issue(v[i]);
      idle();
      repeat (3) @(negedge clk);
      issue_mul(1'b0, 32'd0, 32'd0, 32'd6, 2'd1, 32'd7, 4'b0011, 32'd42, 4'b0011, 1'b1);
      busy_cycles(n);
      chk("mul_busy_k16", 32'(n), 32'd16);
      @(negedge clk);
      issue_mul(1'b1, 32'd3, 32'hFFFFFFFF, 32'd2, 2'd0, 32'd0, 4'b0000, 32'd1, 4'b0000, 1'b1);
      busy_cycles(n);
      chk("mla_busy_k16", 32'(n), 32'd16);
      @(negedge clk);
      issue_mul(1'b0, 32'd0, 32'd0, 32'd5, 2'd0, 32'd0, 4'b0000, 32'd0, 4'b0100, 1'b1);
      busy_cycles(n);
      @(negedge clk);
      issue_mul(1'b0, 32'd0, 32'hFFFFFFFF, 32'd1, 2'd0, 32'd0, 4'b0010, 32'hFFFFFFFF, 4'b1010, 1'b1);
      busy_cycles(n);
      @(negedge clk);
      issue_mul(1'b0, 32'd0, 32'd9, 32'd9, 2'd0, 32'd0, 4'b0000, 32'd0, 4'b0000, 1'b0);
      repeat (4) @(negedge clk);
      b.flush = 1;
      @(negedge clk);
      b.flush = 0;
      chk("flush_in_ready", 32'(b.in_ready), 32'd1);
      chk("flush_out_valid", 32'(b.out_valid), 32'd0);
      repeat (20) @(negedge clk);
      issue(v[0]);
      idle();
      repeat (2) @(negedge clk);
      issue_mul(1'b0, 32'd0, 32'd9, 32'd9, 2'd0, 32'd0, 4'b0000, 32'd0, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      rst = 1;
      check_zero("rst_mid_mul");
      repeat (20) @(negedge clk);
      issue(v[1]);
      idle();
      repeat (2) @(negedge clk);
      b4.in_valid = 1; b4.mul_en = 1; b4.mla_en = 1; b4.s_en = 1; b4.wb_en_in = 1; b4.dest_in = 4'h5;
      b4.val_1 = 32'd3; b4.val_r_m_in = 32'hFFFFFFFF; b4.val_s = 32'd2; b4.status_reg_out = 4'b0000;
      @(negedge clk);
      b4.in_valid = 0; b4.mul_en = 0; b4.mla_en = 0;
      n = 0;
      while (!b4.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("mla_busy_k8", 32'(n), 32'd8);
      chk("mla_k8_out_valid", 32'(b4.out_valid), 32'd1);
      chk("mla_k8_alu_res", b4.alu_res, 32'd1);
      chk("mla_k8_flags", 32'(b4.status_reg_in), 32'd0);
      chk("mla_k8_dest", 32'(b4.dest), 32'd5);
      @(negedge clk);
      chk("mla_k8_out_valid_drop", 32'(b4.out_valid), 32'd0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/exe_stage_iter.md
# exe_stage_iter

Parametrised, registered execute stage for the pipelined ARM core. It extends the single-cycle execute path with an iterative multiplier (MUL/MLA) and 3-way operand forwarding. It also registers all results into the EXE/MEM boundary and emits a stall handshake while a multiply is in flight. It sits between the ID/EXE register and the memory stage, and drives the hazard/forwarding unit through `in_ready`.

## Interface
- `WIDTH`, 32: datapath width, for operands, results and PC.
- `IMM_LEN`, 24: branch immediate width (signed).
- `MUL_STEP`, 2: multiplier bits retired per cycle. Must divide `WIDTH`. K = `WIDTH`/`MUL_STEP`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  kill the in-flight and incoming instruction.
- `in_valid`  in  1  issue request from ID/EXE.
- `in_ready`  out  1  stage can accept; low while multiplying.
- `exec_cmd`  in  4  ALU command, using the existing codebase encoding.
- `mul_en`, `mla_en`  in  1 each  multiply / multiply-accumulate select. `mla_en` implies `mul_en`.
- `s_en`  in  1  update flags.
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in`  in  1 each  control pass-through.
- `dest_in`  in  4  destination register.
- `imm`  in  1  immediate operand select.
- `shift_operand`  in  12  shifter operand.
- `signed_imm`  in  `IMM_LEN`  branch offset, in words.
- `pc_in`  in  `WIDTH`  PC of the next instruction.
- `val_1`, `val_r_m_in`, `val_s`  in  `WIDTH` each  Rn, Rm, Rs operands.
- `status_reg_out`  in  4  current {N,Z,C,V}.
- `alu_src1_mux_sel`, `alu_src2_mux_sel`  in  2 each  0 = register value, 1 = `mem_wb_val`, 2 = `wb_wb_val`, 3 = register value.
- `mem_wb_val`, `wb_wb_val`  in  `WIDTH` each  forwarded values.
- `out_valid`  out  1  registered result valid.
- `alu_res`, `val_r_m`, `branch_addr`  out  `WIDTH` each  registered result, forwarded Rm, and branch target.
- `status_reg_in`  out  4  registered new flags.
- `status_we`  out  1  flag write enable (= `out_valid & s_en`).
- `dest`  out  4  registered destination register.
- `wb_en`, `mem_r_en`, `mem_w_en`  out  1 each  registered control.

## Operation
- Forwarding muxes select src1 (from `val_1`) and src2 (from `val_r_m_in`). `val_2` is produced from src2 by the existing shifter/immediate generator. Memory ops force address-offset mode.
- Accept = `in_valid & in_ready & ~flush`.
- FSM has states IDLE and MUL.
- In IDLE, an accepted non-multiply instruction latches into the outputs:
  - the ALU result and ALU flags;
  - `val_r_m` = src2;
  - `branch_addr` = `pc_in` + (sign-extended `signed_imm` << 2), truncated to `WIDTH`;
  - all controls.
- In IDLE, an accepted multiply latches the operands:
  - multiplicand = src2, multiplier = `val_s`, accumulator = src1 if `mla_en`, else 0;
  - the controls and the C/V bits of `status_reg_out`.
  - State moves to MUL with counter = 0.
- In MUL, each edge adds (multiplicand × next `MUL_STEP` multiplier bits, LSB first) to the partial sum. The partial sum is `WIDTH` bits and the upper bits are discarded.
- The counter increments; the step with counter = K−1 writes the outputs and returns to IDLE.
- Multiply flags: N = res[`WIDTH`−1], Z = (res == 0). C and V keep their latched values.
- When no instruction completes on an edge, `out_valid`, `wb_en`, `mem_r_en`, `mem_w_en` and `status_we` are 0. Data outputs hold their previous values.
- `flush` on an edge forces IDLE, `out_valid` = 0 and all controls = 0. It discards an in-flight multiply and any same-cycle issue.

## Timing
- Reset (`rst` = 0 at an edge) has priority over everything. After reset:
  - all outputs are 0, including `branch_addr` and `status_reg_in`;
  - state = IDLE and `in_ready` = 1.
- Reset mid-multiply aborts it with no output.
- `in_ready` = (state == IDLE). It is combinational from state and does not depend on `in_valid`.
- A non-multiply accepted at edge E0 has `out_valid` = 1 for exactly the cycle after E0.
- A multiply accepted at E0:
  - `in_ready` is low during the K cycles after E0;
  - the result is written at edge E_K, so `out_valid` is high in the cycle after E_K;
  - total latency is K+1 edges from acceptance.
- Upstream must hold its instruction while `in_ready` = 0. `in_valid` is ignored in MUL.
- Back-to-back non-multiply issues sustain 1 instruction/cycle.
- `flush` and completion on the same edge: flush wins and there is no output.
- Forwarded values are sampled only at the acceptance edge. Later changes to `mem_wb_val`/`wb_wb_val` do not affect an in-flight multiply.

## Test plan
- Forwarding: `exec_cmd` = ADD, `imm` = 1, immediate 5, src1 sel = 1, `mem_wb_val` = 10 -> `alu_res` = 15 and `out_valid` = 1 one cycle later.
- MUL, default params (K = 16): Rm = 7, Rs = 6, `s_en` = 1 -> `in_ready` low for 16 cycles, then `alu_res` = 42, N = 0, Z = 0, C/V unchanged.
- MLA wrap: Rm = 0xFFFFFFFF, Rs = 2, Rn = 3 -> `alu_res` = 0x00000001. With `MUL_STEP` = 4, busy lasts 8 cycles.
- Branch: `pc_in` = 0x100, `signed_imm` = 0xFFFFFE -> `branch_addr` = 0xF8.
- Flush abort: assert `flush` on the 5th MUL cycle -> no `out_valid`, and `in_ready` = 1 on the next cycle. A following ADD completes normally.
- Reset: assert `rst` = 0 mid-multiply -> all outputs 0 and IDLE on the next cycle, then normal issue resumes.
